timer_ctrl_master: RTL and testbench

- Avalon-MM initiator that drives one instance of the team's 16-bit-data interval timer slave on behalf of a simple command interface.
- Programs the period and mode, starts and stops the counter, services the timer IRQ by clearing status, and reads back 32-bit counter snapshots.
- Sits between streaming/control logic and the timer slave; this block is the only master on that slave port.

---
 rtl/timer_ctrl_master_if.sv | 19 +
 rtl/timer_ctrl_master.sv | 204 ++++++++++++++++++++
 tb/tb_timer_ctrl_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM link between timer_ctrl_master and the 16-bit interval timer slave.
interface timer_ctrl_master_if;
  logic [2:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_irq;

  modport master (
    output av_address, av_chipselect, av_write_n, av_writedata,
    input  av_readdata, av_irq
  );

  modport slave (
    input  av_address, av_chipselect, av_write_n, av_writedata,
    output av_readdata, av_irq
  );
endinterface

// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator that programs, starts, stops, services and snapshots
// one interval timer slave on behalf of a pulse-based command interface.
//
// state  | meaning
// IDLE   | timer not running, waiting for start/snap
// WR_PL  | write period low half (addr 2)
// WR_PH  | write period high half (addr 3)
// GAP    | bus idle, slave finishes reload/stop before start
// WR_CTL | write control: start | irq enable | continuous (addr 1)
// RUN    | timer running, waiting for irq/start/stop/snap
// CLR_ST | clear status (addr 0), counts a serviced timeout
// ST_CTL | write control: stop, irq disabled (addr 1)
// ST_CLR | clear status after stop (addr 0)
// SN_WR  | write snap register, slave latches counter (addr 4)
// SN_RL  | read snapshot low (addr 4)
// SN_RH  | read snapshot high (addr 5), low data returns
// SN_CAP | bus idle, high data returns, publish snapshot
module timer_ctrl_master #(
  parameter int TICK_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_start,
  input  logic [31:0]           cmd_period,
  input  logic                  cmd_continuous,
  input  logic                  cmd_stop,
  input  logic                  cmd_snap,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  timer_ctrl_master_if.master   av
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_RUN, S_CLR_ST,
    S_ST_CTL, S_ST_CLR, S_SN_WR, S_SN_RL, S_SN_RH, S_SN_CAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_start_acc;
  logic [31:0]           w_period_nxt;
  logic                  w_cs;
  logic                  w_wn;
  logic [2:0]            w_addr;
  logic [15:0]           w_wdata;

  logic [31:0]           r_period;
  logic                  r_cont;
  logic                  r_ret_run;
  logic [15:0]           r_snap_lo;
  logic                  r_cs;
  logic                  r_wn;
  logic [2:0]            r_addr;
  logic [15:0]           r_wdata;
  logic                  r_busy;
  logic                  r_running;
  logic                  r_tick;
  logic [TICK_CNT_W-1:0] r_tick_count;
  logic                  r_snap_valid;
  logic [31:0]           r_snap_value;

  // State register plus command latches and registered bus outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_period  <= '0;
      r_cont    <= 1'b0;
      r_ret_run <= 1'b0;
      r_cs      <= 1'b0;
      r_wn      <= 1'b1;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_period <= cmd_period;
        r_cont   <= cmd_continuous;
      end
      if (w_state_nxt == S_SN_WR) r_ret_run <= (r_state == S_RUN);
      r_cs    <= w_cs;
      r_wn    <= w_wn;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  // Next-state decode; irq outranks every command while running
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_start) begin
          w_state_nxt = S_WR_PL;
          w_start_acc = 1'b1;
        end else if (cmd_snap) begin
          w_state_nxt = S_SN_WR;
        end
      end
      S_WR_PL:  w_state_nxt = S_WR_PH;
      S_WR_PH:  w_state_nxt = S_GAP;
      S_GAP:    w_state_nxt = S_WR_CTL;
      S_WR_CTL: w_state_nxt = S_RUN;
      S_RUN: begin
        if (av.av_irq) begin
          w_state_nxt = S_CLR_ST;
        end else if (cmd_start) begin
          w_state_nxt = S_WR_PL;
          w_start_acc = 1'b1;
        end else if (cmd_stop) begin
          w_state_nxt = S_ST_CTL;
        end else if (cmd_snap) begin
          w_state_nxt = S_SN_WR;
        end
      end
      S_CLR_ST: w_state_nxt = r_cont ? S_RUN : S_IDLE;
      S_ST_CTL: w_state_nxt = S_ST_CLR;
      S_ST_CLR: w_state_nxt = S_IDLE;
      S_SN_WR:  w_state_nxt = S_SN_RL;
      S_SN_RL:  w_state_nxt = S_SN_RH;
      S_SN_RH:  w_state_nxt = S_SN_CAP;
      S_SN_CAP: w_state_nxt = r_ret_run ? S_RUN : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bus values for the upcoming state, so they register in with the state
  always_comb begin
    w_period_nxt = w_start_acc ? cmd_period : r_period;
    w_cs    = 1'b0;
    w_wn    = 1'b1;
    w_addr  = 3'd0;
    w_wdata = 16'h0000;
    case (w_state_nxt)
      S_WR_PL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd2; w_wdata = w_period_nxt[15:0];
      end
      S_WR_PH: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd3; w_wdata = w_period_nxt[31:16];
      end
      S_WR_CTL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1;
        w_wdata = 16'h0005 | {14'd0, r_cont, 1'b0};
      end
      S_CLR_ST, S_ST_CLR: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd0;
      end
      S_ST_CTL: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd1; w_wdata = 16'h0008;
      end
      S_SN_WR: begin
        w_cs = 1'b1; w_wn = 1'b0; w_addr = 3'd4;
      end
      S_SN_RL: begin
        w_cs = 1'b1; w_addr = 3'd4;
      end
      S_SN_RH: begin
        w_cs = 1'b1; w_addr = 3'd5;
      end
      default: ;
    endcase
  end

  // Status outputs: busy/tick follow the upcoming state, snapshot halves follow read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy       <= 1'b0;
      r_running    <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_snap_lo    <= '0;
      r_snap_valid <= 1'b0;
      r_snap_value <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_RUN);
      r_tick <= (w_state_nxt == S_CLR_ST);
      if (w_state_nxt == S_CLR_ST) r_tick_count <= r_tick_count + 1'b1;
      if (r_state == S_WR_CTL) begin
        r_running <= 1'b1;
      end else if ((r_state == S_CLR_ST && !r_cont) || r_state == S_ST_CLR) begin
        r_running <= 1'b0;
      end
      if (r_state == S_SN_RH) r_snap_lo <= av.av_readdata;
      r_snap_valid <= (r_state == S_SN_CAP);
      if (r_state == S_SN_CAP) r_snap_value <= {av.av_readdata, r_snap_lo};
    end
  end

  assign av.av_chipselect = r_cs;
  assign av.av_write_n    = r_wn;
  assign av.av_address    = r_addr;
  assign av.av_writedata  = r_wdata;
  assign busy             = r_busy;
  assign running          = r_running;
  assign tick             = r_tick;
  assign tick_count       = r_tick_count;
  assign snap_valid       = r_snap_valid;
  assign snap_value       = r_snap_value;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: behavioural timer slave plus a transaction-level
// model that lists the bus beats each command must produce.
module tb_timer_ctrl_master;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_start, cmd_continuous, cmd_stop, cmd_snap;
  logic [31:0]   cmd_period;
  logic          busy, running, tick, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;

  timer_ctrl_master_if bus ();

  timer_ctrl_master #(.TICK_CNT_W(TW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
    .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_valid(snap_valid), .snap_value(snap_value),
    .av(bus)
  );

  always #5 clk = ~clk;

  // timer slave: registered reads, snapshot latch, irq held until status write
  logic        irq_req;
  logic        s_irq;
  logic [15:0] s_rdata;
  logic [31:0] s_counter;
  logic [31:0] s_latch;
  logic [15:0] s_reg [0:7];

  assign bus.av_irq      = s_irq;
  assign bus.av_readdata = s_rdata;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_irq   <= 1'b0;
      s_rdata <= 16'h0;
      s_latch <= 32'h0;
      for (int i = 0; i < 8; i++) s_reg[i] <= 16'h0;
    end else begin
      s_rdata <= 16'h0;
      if (bus.av_chipselect && !bus.av_write_n) begin
        s_reg[bus.av_address] <= bus.av_writedata;
        if (bus.av_address == 3'd4) s_latch <= s_counter;
      end
      if (bus.av_chipselect && bus.av_write_n)
        s_rdata <= (bus.av_address == 3'd4) ? s_latch[15:0] :
                   (bus.av_address == 3'd5) ? s_latch[31:16] : s_reg[bus.av_address];
      if (bus.av_chipselect && !bus.av_write_n && bus.av_address == 3'd0) s_irq <= 1'b0;
      else if (irq_req) s_irq <= 1'b1;
    end
  end

  typedef struct packed {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        busy;
    logic        tick;
    logic        sv;
  } beat_t;

  beat_t         exp_q[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [TW-1:0] m_ticks;
  logic          m_running;
  logic          m_cont;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic beat_t mk(input logic cs, input logic wn, input logic [2:0] a,
                               input logic [15:0] d, input logic b, input logic t, input logic s);
    beat_t r;
    r.cs = cs; r.wn = wn; r.addr = a; r.data = d; r.busy = b; r.tick = t; r.sv = s;
    return r;
  endfunction

  function automatic beat_t wr(input logic [2:0] a, input logic [15:0] d);
    return mk(1'b1, 1'b0, a, d, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic beat_t rd(input logic [2:0] a);
    return mk(1'b1, 1'b1, a, 16'h0, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic beat_t idle(input logic b);
    return mk(1'b0, 1'b1, 3'd0, 16'h0, b, 1'b0, 1'b0);
  endfunction

  task automatic step_chk(input beat_t e);
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0; irq_req = 1'b0;
    if (e.tick) m_ticks = m_ticks + 1'b1;
    chk("bus", {11'd0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
        {11'd0, e.cs, e.wn, e.addr, e.data});
    chk("busy", {31'd0, busy}, {31'd0, e.busy});
    chk("tick", {31'd0, tick}, {31'd0, e.tick});
    chk("snap_valid", {31'd0, snap_valid}, {31'd0, e.sv});
    chk("tick_count", {16'd0, tick_count}, {16'd0, m_ticks});
  endtask

  task automatic run_q();
    while (exp_q.size() > 0) step_chk(exp_q.pop_front());
  endtask

  task automatic chk_reset_vals();
    chk("rst_bus", {11'd0, bus.av_chipselect, bus.av_write_n, bus.av_address, bus.av_writedata},
        {11'd0, 1'b0, 1'b1, 3'd0, 16'h0});
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_tick", {31'd0, tick}, 32'd0);
    chk("rst_tick_count", {16'd0, tick_count}, 32'd0);
    chk("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
    chk("rst_snap_value", snap_value, 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0; irq_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    m_ticks = '0; m_running = 1'b0; m_cont = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic op_start(input logic [31:0] p, input logic c);
    cmd_period = p; cmd_continuous = c; cmd_start = 1'b1;
    exp_q.push_back(wr(3'd2, p[15:0]));
    exp_q.push_back(wr(3'd3, p[31:16]));
    exp_q.push_back(idle(1'b1));
    exp_q.push_back(wr(3'd1, c ? 16'h0007 : 16'h0005));
    exp_q.push_back(idle(1'b0));
    run_q();
    m_running = 1'b1; m_cont = c;
    chk("running_after_start", {31'd0, running}, {31'd0, m_running});
    chk("slave_period", {s_reg[3], s_reg[2]}, p);
  endtask

  task automatic op_irq();
    irq_req = 1'b1;
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(idle(1'b0));
    exp_q.push_back(idle(1'b0));
    run_q();
    if (!m_cont) m_running = 1'b0;
    chk("running_after_irq", {31'd0, running}, {31'd0, m_running});
  endtask

  task automatic op_snap(input logic [31:0] v);
    s_counter = v; cmd_snap = 1'b1;
    exp_q.push_back(wr(3'd4, 16'h0));
    exp_q.push_back(rd(3'd4));
    exp_q.push_back(rd(3'd5));
    exp_q.push_back(idle(1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b1));
    run_q();
    chk("snap_value", snap_value, v);
    chk("running_after_snap", {31'd0, running}, {31'd0, m_running});
  endtask

  task automatic op_stop();
    cmd_stop = 1'b1;
    if (m_running) begin
      exp_q.push_back(wr(3'd1, 16'h0008));
      exp_q.push_back(wr(3'd0, 16'h0000));
      exp_q.push_back(idle(1'b0));
    end else begin
      repeat (3) exp_q.push_back(idle(1'b0));
    end
    run_q();
    m_running = 1'b0;
    chk("running_after_stop", {31'd0, running}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    reset_n = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0; irq_req = 1'b0;
    cmd_period = 32'h0; cmd_continuous = 1'b0; s_counter = 32'h0;
    m_ticks = '0; m_running = 1'b0; m_cont = 1'b0;
    @(negedge clk);
    do_reset();

    // continuous start, two serviced timeouts, snapshot while running
    op_start(32'h0001_86A0, 1'b1);
    op_irq();
    op_irq();
    op_snap(32'h00AB_1234);

    // stop arriving with irq: irq first, then stop; start while busy is dropped
    irq_req = 1'b1;
    step_chk(idle(1'b0));
    cmd_stop = 1'b1;
    step_chk(mk(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b1, 1'b0));
    step_chk(idle(1'b0));
    cmd_stop = 1'b1;
    step_chk(wr(3'd1, 16'h0008));
    cmd_period = 32'hDEAD_BEEF; cmd_continuous = 1'b1; cmd_start = 1'b1;
    step_chk(wr(3'd0, 16'h0000));
    step_chk(idle(1'b0));
    step_chk(idle(1'b0));
    m_running = 1'b0;
    chk("running_after_stop_irq", {31'd0, running}, 32'd0);

    // one-shot: serviced once, then a later irq is left alone
    op_start($urandom, 1'b0);
    op_irq();
    irq_req = 1'b1;
    repeat (4) step_chk(idle(1'b0));
    chk("oneshot_running", {31'd0, running}, 32'd0);
    do_reset();

    // randomized command mix, period 0 included
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          p = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
          op_start(p, 1'(($urandom_range(0, 1))));
        end
        1: if (m_running) op_irq(); else op_snap($urandom);
        2: op_snap($urandom);
        default: op_stop();
      endcase
    end

    // reset in the middle of a re-program
    op_start(32'h0000_0010, 1'b1);
    op_irq();
    cmd_period = 32'h1234_5678; cmd_continuous = 1'b0; cmd_start = 1'b1;
    step_chk(wr(3'd2, 16'h5678));
    step_chk(wr(3'd3, 16'h1234));
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals();
    m_ticks = '0; m_running = 1'b0; m_cont = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step_chk(idle(1'b0));
    step_chk(idle(1'b0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
